// File: rtl/mtncl_pkg.sv
// Shared MTNCL definitions: transmitter state encoding, the dual-rail NULL
// code and the single-rail to dual-rail bit encoder. Also intended for the
// receive side of the sync/MTNCL boundary.
`timescale 1ns/1ps
package mtncl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA_OUT = 2'd1,
        NULL_OUT = 2'd2
    } tx_state_t;

    // Dual-rail code for one bit as {rail1, rail0}; both low is NULL.
    localparam logic [1:0] DR_NULL = 2'b00;

    // Encode one single-rail bit into its dual-rail DATA code {rail1, rail0}.
    function automatic logic [1:0] dr_encode(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mtncl_ack_sync.sv
// Multi-flop synchronizer bringing the asynchronous MTNCL ko acknowledge
// into the clk domain. Chain resets to 0 (request-for-NULL), so nothing is
// launched until the stage actually requests DATA.
`timescale 1ns/1ps
module mtncl_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw acknowledge through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/mtncl_sync_tx.sv
// Clocked-to-MTNCL transmitter. Accepts single-rail words over valid/ready
// and drives each one as a DATA wavefront followed by a NULL wavefront on
// the z1/z0 dual-rail bus, paced by the synchronized ko acknowledge.
// Optional feature macro: MTNCL_TX_TIMEOUT_EN (ack wait limit, sticky err).
`timescale 1ns/1ps
module mtncl_sync_tx
    import mtncl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             ko,
    output logic [WIDTH-1:0] z1,
    output logic [WIDTH-1:0] z0,
    output logic             busy,
    output logic             err
);

    tx_state_t        state;
    logic             ko_s;
    logic [WIDTH-1:0] enc_z1;
    logic [WIDTH-1:0] enc_z0;
    logic             accept;

    mtncl_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ko),
        .sync_out (ko_s)
    );

    assign accept = (state == IDLE) && s_valid && s_ready;

    // Dual-rail DATA code of the incoming word, captured only on accept.
    always_comb begin
        enc_z1 = '0;
        enc_z0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {enc_z1[i], enc_z0[i]} = dr_encode(s_data[i]);
        end
    end

`ifdef MTNCL_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             leaving;
    logic             timeout;

    // A state exit restarts the wait count for the state being entered.
    assign leaving = accept
                   || ((state == DATA_OUT) && !ko_s)
                   || ((state == NULL_OUT) &&  ko_s);
    assign timeout = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign err     = err_q;
`else
    // Timeout compiled out: err is constant 0 (TIMEOUT_CYC kept so both
    // builds share one parameter interface).
    assign err = 1'b0 & (TIMEOUT_CYC == 0);
`endif

    // Wavefront sequencer: IDLE -> DATA_OUT -> NULL_OUT -> IDLE, with all
    // outputs registered so ko and s_data never reach the rails combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            z1      <= {WIDTH{DR_NULL[1]}};
            z0      <= {WIDTH{DR_NULL[0]}};
            s_ready <= 1'b0;
            busy    <= 1'b0;
`ifdef MTNCL_TX_TIMEOUT_EN
            cnt     <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= DATA_OUT;
                        z1      <= enc_z1;
                        z0      <= enc_z0;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        s_ready <= ko_s;
                    end
                end
                DATA_OUT: begin
                    if (!ko_s) begin
                        state <= NULL_OUT;
                        z1    <= {WIDTH{DR_NULL[1]}};
                        z0    <= {WIDTH{DR_NULL[0]}};
                    end
                end
                NULL_OUT: begin
                    if (ko_s) begin
                        state   <= IDLE;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    z1      <= {WIDTH{DR_NULL[1]}};
                    z0      <= {WIDTH{DR_NULL[0]}};
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
`ifdef MTNCL_TX_TIMEOUT_EN
            if (leaving || (state == IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // A stalled acknowledge abandons the wavefront: flag it and
            // park in NULL_OUT so the rails are left at NULL.
            if (timeout) begin
                err_q   <= 1'b1;
                state   <= NULL_OUT;
                z1      <= {WIDTH{DR_NULL[1]}};
                z0      <= {WIDTH{DR_NULL[0]}};
                s_ready <= 1'b0;
                busy    <= 1'b1;
                cnt     <= '0;
            end
`endif
        end
    end

endmodule
